// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Data words are zero-padded to MAX_DATA_BITS before the parity helper is applied.
package uart_pkg;

  typedef enum logic [2:0] {
    AGUARDA_DADO,
    GERA_START,
    TRANS_DADO,
    TRANS_PARIDADE,
    GERA_STOP1,
    GERA_STOP2
  } estado_tipo;

  typedef enum logic [1:0] {
    NENHUMA = 2'b00,
    PAR     = 2'b01,
    IMPAR   = 2'b10
  } paridade_t;

  localparam int MAX_DATA_BITS = 9;

  // Mode 2'b11 falls through to "no parity", same as NENHUMA.
  function automatic logic paridade_ativa(input logic [1:0] modo);
    return (modo == PAR) || (modo == IMPAR);
  endfunction

  function automatic logic bit_paridade(input logic [MAX_DATA_BITS-1:0] dado,
                                        input logic [1:0] modo);
    return (modo == IMPAR) ? ~(^dado) : (^dado);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last clk cycle of each serial bit.
// limpa holds the count at zero so every new bit period starts clean.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic limpa,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (limpa || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == ULTIMO);

endmodule

// File: rtl/codificador_uart_param.sv
// UART transmitter with a one-word holding buffer, runtime parity and 1/2 stop bits.
// TX/transmitindo/fim are registered copies of the state decode, one cycle behind the FSM.
module codificador_uart_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] dado,
  input  logic                 dado_valido,
  input  logic [1:0]           paridade_modo,
  input  logic                 stop_1_2,
  output logic                 pronto,
  output logic                 TX,
  output logic                 transmitindo,
  output logic                 fim
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] ULTIMO_BIT = BIT_W'(DATA_BITS - 1);

  estado_tipo r_estado, w_proximo;

  logic [DATA_BITS-1:0] r_buf_dado;
  logic [1:0]           r_buf_modo;
  logic                 r_buf_stop2;
  logic                 r_cheio;

  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_stop2;

  logic r_tx, r_transmitindo, r_fim;
  logic w_tick, w_limpa, w_tx, w_fim_quadro, w_carrega;

  assign w_limpa = (r_estado == AGUARDA_DADO);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .limpa (w_limpa),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado <= AGUARDA_DADO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // End of frame chains straight into the next start bit when the buffer is full.
  always_comb begin
    w_proximo    = r_estado;
    w_tx         = 1'b1;
    w_fim_quadro = 1'b0;
    case (r_estado)
      AGUARDA_DADO: begin
        if (r_cheio) w_proximo = GERA_START;
      end
      GERA_START: begin
        w_tx = 1'b0;
        if (w_tick) w_proximo = TRANS_DADO;
      end
      TRANS_DADO: begin
        w_tx = r_shift[0];
        if (w_tick && (r_bit == ULTIMO_BIT))
          w_proximo = r_par_en ? TRANS_PARIDADE : GERA_STOP1;
      end
      TRANS_PARIDADE: begin
        w_tx = r_par_bit;
        if (w_tick) w_proximo = GERA_STOP1;
      end
      GERA_STOP1: begin
        if (w_tick) begin
          if (r_stop2) w_proximo = GERA_STOP2;
          else         w_fim_quadro = 1'b1;
        end
      end
      GERA_STOP2: begin
        if (w_tick) w_fim_quadro = 1'b1;
      end
      default: w_proximo = AGUARDA_DADO;
    endcase
    if (w_fim_quadro) w_proximo = r_cheio ? GERA_START : AGUARDA_DADO;
    w_carrega = r_cheio && ((r_estado == AGUARDA_DADO) || w_fim_quadro);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf_dado  <= '0;
      r_buf_modo  <= '0;
      r_buf_stop2 <= 1'b0;
      r_cheio     <= 1'b0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop2     <= 1'b0;
    end else begin
      if (w_carrega) begin
        r_cheio <= 1'b0;
      end else if (dado_valido && pronto) begin
        r_buf_dado  <= dado;
        r_buf_modo  <= paridade_modo;
        r_buf_stop2 <= stop_1_2;
        r_cheio     <= 1'b1;
      end
      if (w_carrega) begin
        r_shift   <= r_buf_dado;
        r_bit     <= '0;
        r_par_en  <= paridade_ativa(r_buf_modo);
        r_par_bit <= bit_paridade(MAX_DATA_BITS'(r_buf_dado), r_buf_modo);
        r_stop2   <= r_buf_stop2;
      end else if ((r_estado == TRANS_DADO) && w_tick && (r_bit != ULTIMO_BIT)) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx           <= 1'b1;
      r_transmitindo <= 1'b0;
      r_fim          <= 1'b0;
    end else begin
      r_tx           <= w_tx;
      r_transmitindo <= (r_estado != AGUARDA_DADO);
      r_fim          <= w_fim_quadro;
    end
  end

  assign pronto       = !r_cheio;
  assign TX           = r_tx;
  assign transmitindo = r_transmitindo;
  assign fim          = r_fim;

endmodule

// File: tb/tb_codificador_uart_param.sv
// Directed bench for codificador_uart_param: an 8-bit and a 7-bit instance, both at 4 clks/bit.
// Expected frames are written out by hand as {stop(s), parity, data, start}, bit 0 sent first.
module tb_codificador_uart_param;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dado8 = '0;
  logic [6:0] dado7 = '0;
  logic       valid8 = 1'b0;
  logic       valid7 = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       stop2 = 1'b0;
  logic       pronto8, tx8, tr8, fim8;
  logic       pronto7, tx7, tr7, fim7;
  logic       sel7 = 1'b0;
  logic       mPronto, mTx, mTr, mFim;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  codificador_uart_param #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .dado(dado8), .dado_valido(valid8),
    .paridade_modo(modo), .stop_1_2(stop2),
    .pronto(pronto8), .TX(tx8), .transmitindo(tr8), .fim(fim8)
  );

  codificador_uart_param #(.DATA_BITS(7), .CLKS_PER_BIT(4)) dut7 (
    .clk(clk), .reset(reset), .dado(dado7), .dado_valido(valid7),
    .paridade_modo(modo), .stop_1_2(stop2),
    .pronto(pronto7), .TX(tx7), .transmitindo(tr7), .fim(fim7)
  );

  assign mPronto = sel7 ? pronto7 : pronto8;
  assign mTx     = sel7 ? tx7 : tx8;
  assign mTr     = sel7 ? tr7 : tr8;
  assign mFim    = sel7 ? fim7 : fim8;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  modo;
    logic        stop2;
    logic [31:0] bits;
    int          nBits;
  } vetor_t;

  vetor_t vetores[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for pronto, transfers one word, then scrambles the inputs.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] m, input logic s2);
    int waited = 0;
    while (!mPronto && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("pronto_before_send", 32'(mPronto), 32'd1);
    if (sel7) begin dado7 = data[6:0]; valid7 = 1'b1; end
    else      begin dado8 = data;      valid8 = 1'b1; end
    modo = m;
    stop2 = s2;
    @(posedge clk); #1;
    valid7 = 1'b0;
    valid8 = 1'b0;
    dado7 = ~data[6:0];
    dado8 = ~data;
    modo = ~m;
    stop2 = ~s2;
  endtask

  // Called 1ns after the transfer edge; checks latency, every TX cycle, fim and transmitindo.
  task automatic captureFrame(input string name, input logic [31:0] bits, input int nBits,
                              input int fimA, input int fimB, input logic feed,
                              input logic [7:0] nextData, input logic [1:0] nextModo,
                              input logic nextStop);
    int txErr = 0;
    int fimErr = 0;
    int trErr = 0;
    logic acc;
    @(negedge clk);
    checkOutput({name, "_lat0"}, 32'(mTx), 32'd1);
    @(posedge clk); #1;
    if (feed) begin
      dado8 = nextData; modo = nextModo; stop2 = nextStop; valid8 = 1'b1;
    end
    @(negedge clk);
    checkOutput({name, "_lat1"}, 32'(mTx), 32'd1);
    for (int c = 0; c < nBits * 4; c++) begin
      acc = valid8 && pronto8;
      @(posedge clk); #1;
      if (acc) begin
        valid8 = 1'b0; dado8 = ~nextData; modo = ~nextModo; stop2 = ~nextStop;
      end
      @(negedge clk);
      if (mTx !== bits[c/4]) txErr++;
      if (mFim !== ((c == fimA) || (c == fimB))) fimErr++;
      if (mTr !== 1'b1) trErr++;
    end
    checkOutput({name, "_tx_bits"}, 32'(txErr), 32'd0);
    checkOutput({name, "_fim"}, 32'(fimErr), 32'd0);
    checkOutput({name, "_transmitindo"}, 32'(trErr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_idle_tx"}, 32'(mTx), 32'd1);
    checkOutput({name, "_idle_tr"}, 32'(mTr), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idleErr;

    vetores[0] = '{8'hA5, PAR,    1'b0, 32'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    vetores[1] = '{8'h01, IMPAR,  1'b0, 32'({1'b1, 1'b0, 8'h01, 1'b0}), 11};
    vetores[2] = '{8'h01, PAR,    1'b0, 32'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
    vetores[3] = '{8'hFF, 2'b11,  1'b0, 32'({1'b1, 8'hFF, 1'b0}), 10};
    vetores[4] = '{8'hC3, IMPAR,  1'b1, 32'({2'b11, 1'b1, 8'hC3, 1'b0}), 12};
    vetores[5] = '{8'h00, PAR,    1'b1, 32'({2'b11, 1'b0, 8'h00, 1'b0}), 12};
    vetores[6] = '{8'h80, NENHUMA,1'b0, 32'({1'b1, 8'h80, 1'b0}), 10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_tx", 32'(tx8), 32'd1);
    checkOutput("reset_pronto", 32'(pronto8), 32'd1);
    checkOutput("reset_transmitindo", 32'(tr8), 32'd0);
    checkOutput("reset_fim", 32'(fim8), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vetores[i].data, vetores[i].modo, vetores[i].stop2);
      captureFrame($sformatf("vec%0d", i), vetores[i].bits, vetores[i].nBits,
                   vetores[i].nBits * 4 - 1, -1, 1'b0, 8'h00, 2'b00, 1'b0);
      @(posedge clk); #1;
    end

    // 7-bit instance, no parity, two stops: 10-bit frame ending in 8 high cycles.
    sel7 = 1'b1;
    applyStimulus(8'h7F, NENHUMA, 1'b1);
    captureFrame("d7_7F", 32'({2'b11, 7'h7F, 1'b0}), 10, 39, -1, 1'b0, 8'h00, 2'b00, 1'b0);
    sel7 = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: second word offered while the first is on the line.
    applyStimulus(8'h3C, NENHUMA, 1'b1);
    captureFrame("b2b", 32'({2'b11, 1'b1, 8'hC3, 1'b0, 2'b11, 8'h3C, 1'b0}), 23, 43, 91,
                 1'b1, 8'hC3, IMPAR, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of the data bits with the buffer refilled.
    applyStimulus(8'h00, PAR, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dado8 = 8'h99; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    checkOutput("midframe_tx_low", 32'(tx8), 32'd0);
    checkOutput("midframe_buffer_full", 32'(pronto8), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_tx", 32'(tx8), 32'd1);
    checkOutput("abort_pronto", 32'(pronto8), 32'd1);
    checkOutput("abort_transmitindo", 32'(tr8), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idleErr = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if ((tx8 !== 1'b1) || (tr8 !== 1'b0)) idleErr++;
    end
    checkOutput("after_reset_silent", 32'(idleErr), 32'd0);
    @(posedge clk); #1;
    applyStimulus(8'h81, PAR, 1'b0);
    captureFrame("after_reset_81", 32'({1'b1, 1'b0, 8'h81, 1'b0}), 11, 43, -1,
                 1'b0, 8'h00, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
